// File: rtl/max7219_rx.sv
// max7219_rx: SPI slave that decodes 16-bit MSB-first frames into a MAX7219-style register file.
module max7219_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    cs_n,
  input  logic                    sck,
  input  logic                    mosi,
  output logic [15:0]             word_out,
  output logic                    word_valid,
  output logic                    frame_err,
  output logic [8*NUM_DIGITS-1:0] digits,
  output logic [7:0]              decode_mode,
  output logic [3:0]              intensity,
  output logic [2:0]              scan_limit,
  output logic                    shutdown_n,
  output logic                    display_test
);
  typedef enum logic [1:0] {SYNC_WAIT, IDLE, SHIFT, COMMIT} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_mosi_sync;
  logic r_sck_prev;
  logic [15:0] r_shift;
  logic [4:0] r_cnt;
  logic w_cs, w_sck, w_mosi, w_sck_rise, w_full, w_commit;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_full     = r_cnt == 5'd16;
  assign w_commit   = (r_state == COMMIT) & w_full;
  assign w_addr     = r_shift[11:8];
  assign w_data     = r_shift[7:0];
  always_ff @(posedge clk) begin
    if (res) r_state <= SYNC_WAIT;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      SYNC_WAIT: w_next = w_cs ? IDLE : SYNC_WAIT;
      IDLE:      w_next = w_cs ? IDLE : SHIFT;
      SHIFT:     w_next = w_cs ? COMMIT : SHIFT;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (res) begin
      r_cs_sync    <= '0;
      r_sck_sync   <= '0;
      r_mosi_sync  <= '0;
      r_sck_prev   <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      frame_err    <= 1'b0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_prev  <= w_sck;
      word_valid  <= w_commit;
      frame_err   <= (r_state == COMMIT) & ~w_full;
      if (r_state == IDLE && !w_cs) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end
      // an edge coincident with the cs_n rise is still shifted before COMMIT
      if (r_state == SHIFT && w_sck_rise) begin
        r_shift <= {r_shift[14:0], w_mosi};
        r_cnt   <= w_full ? r_cnt : r_cnt + 5'd1;
      end
      if (w_commit) begin
        word_out <= r_shift;
        for (int i = 0; i < NUM_DIGITS; i++)
          if (w_addr == 4'(i + 1)) digits[8*i +: 8] <= w_data;
        if (w_addr == 4'h9) decode_mode  <= w_data;
        if (w_addr == 4'hA) intensity    <= w_data[3:0];
        if (w_addr == 4'hB) scan_limit   <= w_data[2:0];
        if (w_addr == 4'hC) shutdown_n   <= w_data[0];
        if (w_addr == 4'hF) display_test <= w_data[0];
      end
    end
  end
endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: directed and random SPI frames checked against a register-file model.
module tb_max7219_rx;
  localparam int SS = 2;
  localparam int ND = 8;
  logic clk = 1'b0, res = 1'b1, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic [15:0] word_out;
  logic word_valid, frame_err;
  logic [8*ND-1:0] digits;
  logic [7:0] decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic shutdown_n, display_test;
  max7219_rx #(.SYNC_STAGES(SS), .NUM_DIGITS(ND)) dut (
    .clk(clk), .res(res), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .word_out(word_out), .word_valid(word_valid), .frame_err(frame_err),
    .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test)
  );
  always #500 clk = ~clk;
  typedef struct packed {logic err; logic [15:0] w;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  bit en = 1'b0;
  logic [7:0] m_dig[ND];
  logic [15:0] m_word;
  logic [7:0] m_dec;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic m_shut, m_test;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model_clear();
    foreach (m_dig[i]) m_dig[i] = 8'h00;
    m_word = '0; m_dec = '0; m_int = '0; m_scan = '0; m_shut = 1'b0; m_test = 1'b0;
  endfunction
  function automatic void apply(input logic [15:0] w);
    int a = int'(w[11:8]);
    m_word = w;
    if (a >= 1 && a <= ND) m_dig[a-1] = w[7:0];
    if (a == 9)  m_dec  = w[7:0];
    if (a == 10) m_int  = w[3:0];
    if (a == 11) m_scan = w[2:0];
    if (a == 12) m_shut = w[0];
    if (a == 15) m_test = w[0];
  endfunction
  function automatic logic [8*ND-1:0] exp_digits();
    logic [8*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[8*i +: 8] = m_dig[i];
    return r;
  endfunction
  always @(negedge clk) if (en) begin
    ev_t e;
    chk("pulse_overlap", word_valid & frame_err, 0);
    if (word_valid || frame_err) begin
      if (q.size() == 0) chk("spurious_pulse", {word_valid, frame_err}, 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind", frame_err, e.err);
        if (!e.err && word_valid) apply(e.w);
      end
    end
    chk("word_out", word_out, m_word);
    chk("digits", digits, exp_digits());
    chk("decode_mode", decode_mode, m_dec);
    chk("intensity", intensity, m_int);
    chk("scan_limit", scan_limit, m_scan);
    chk("shutdown_n", shutdown_n, m_shut);
    chk("display_test", display_test, m_test);
  end
  task automatic send_bits(input logic [31:0] val, input int hi, input int lo, input int half);
    for (int i = hi; i >= lo; i--) begin
      mosi = val[i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic frame(input logic [31:0] val, input int n, input int half);
    ev_t e;
    @(negedge clk) cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(val, n - 1, 0, half);
    e.err = n < 16;
    e.w = val[15:0];
    q.push_back(e);
    @(negedge clk) cs_n = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1 chk("latency_early", n >= 16 ? word_valid : frame_err, 0);
    @(posedge clk);
    #1 chk("latency", n >= 16 ? word_valid : frame_err, 1);
    repeat (SS + 4) @(negedge clk);
    chk("pending_events", q.size(), 0);
  endtask
  task automatic do_reset();
    @(negedge clk) res = 1'b1;
    @(posedge clk);
    #1 model_clear();
    q.delete();
    repeat (2) @(negedge clk);
    res = 1'b0;
  endtask
  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, nb;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_word_out", word_out, 0);
    chk("rst_pulses", {word_valid, frame_err}, 0);
    chk("rst_digits", digits, 0);
    chk("rst_regs", {decode_mode, intensity, scan_limit, shutdown_n, display_test}, 0);
    res = 1'b0;
    en = 1'b1;
    repeat (4) @(negedge clk);
    frame(32'h0C01, 16, 2);
    chk("lit_shutdown", shutdown_n, 1);
    chk("lit_word_0c01", word_out, 16'h0C01);
    chk("lit_others_zero", {digits, decode_mode, intensity, scan_limit, display_test}, 0);
    frame(32'h093F, 16, 2);
    frame(32'h0B05, 16, 3);
    frame(32'h0A07, 16, 2);
    chk("lit_decode", decode_mode, 8'h3F);
    chk("lit_scan", scan_limit, 3'd5);
    chk("lit_intensity", intensity, 4'd7);
    frame(32'h0103, 16, 2);
    frame(32'h0205, 16, 2);
    frame(32'h0389, 16, 2);
    frame(32'h0402, 16, 2);
    frame(32'h0587, 16, 2);
    frame(32'h0601, 16, 2);
    chk("lit_digits", digits, 64'h0000_0187_0289_0503);
    frame(32'h01FF, 9, 2);
    chk("lit_short_word", word_out, 16'h0601);
    frame(32'hA0F07, 20, 2);
    chk("lit_overlong_word", word_out, 16'h0F07);
    chk("lit_display_test", display_test, 1);
    @(negedge clk) cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(32'h0109, 15, 8, 2);
    do_reset();
    send_bits(32'h0109, 7, 0, 2);
    @(negedge clk) cs_n = 1'b1;
    repeat (SS + 6) @(negedge clk);
    chk("lit_reset_digit0", digits[7:0], 8'h00);
    frame(32'h0109, 16, 2);
    chk("lit_digit0", digits[7:0], 8'h09);
    frame(32'h0DFF, 16, 2);
    frame(32'h0EFF, 16, 2);
    frame(32'h00FF, 16, 2);
    frame(32'h09FF, 16, 2);
    chk("lit_ignored_decode", decode_mode, 8'hFF);
    chk("lit_ignored_digits", digits, 64'h09);
    chk("lit_ignored_word", word_out, 16'h09FF);
    for (int k = 0; k < 40; k++) begin
      n = int'($urandom_range(0, 9));
      nb = n < 6 ? 16 : n < 8 ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 15));
      frame($urandom, nb, int'($urandom_range(2, 4)));
    end
    repeat (10) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/max7219_rx.md
Name: max7219_rx

Overview:
- SPI slave receiving the 16-bit MSB-first frames that the display SPI master sends, and decoding them into a MAX7219-compatible register file.
- Used as the on-chip loopback or checker for the display path, and as an alternative display sink driving digits without the external driver.
- Runs on the 1 MHz system clock. Oversamples Cs / Clk_SPI / Mosi through synchronizers. The master's SCK phase is at least 2 system clocks wide.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on cs, sck and mosi (minimum 2).
- NUM_DIGITS, 8, number of digit registers implemented (1-8). Addresses above NUM_DIGITS are ignored.

Ports:
- clk  input  1  system clock, 1 MHz.
- res  input  1  reset, synchronous, active-high.
- cs_n  input  1  SPI chip select, active low, asynchronous to clk.
- sck  input  1  SPI serial clock, asynchronous to clk. Data is sampled on its rising edge.
- mosi  input  1  SPI data, MSB first.
- word_out  output  16  last committed frame.
- word_valid  output  1  one-cycle pulse when a frame is committed.
- frame_err  output  1  one-cycle pulse when a short frame (<16 bits) is discarded.
- digits  output  8*NUM_DIGITS  digit registers. Digit n is at bits [8n+7:8n].
- decode_mode  output  8  register 0x9.
- intensity  output  4  register 0xA, bits [3:0].
- scan_limit  output  3  register 0xB, bits [2:0].
- shutdown_n  output  1  register 0xC, bit 0 (0 = shutdown).
- display_test  output  1  register 0xF, bit 0.

Behaviour:
- Reset (res=1 at a clk edge): all outputs are 0, including the word/frame pulses and all registers. The shift register and bit counter are 0, and the state is SYNC_WAIT.
- Synchronizers: cs_n, sck and mosi each pass through SYNC_STAGES flops. The sck rising edge is detected from the last two synchronized sck samples. mosi is taken from the same synchronized stage as sck.
- States:
  - SYNC_WAIT: wait for synchronized cs_n=1, then go to IDLE. This guarantees a frame in progress during reset is never partially decoded.
  - IDLE: on synchronized cs_n=0, clear shift register and bit_cnt, go to SHIFT. sck edges are ignored.
  - SHIFT: each detected sck rising edge does shift <= {shift[14:0], mosi}, and bit_cnt increments, saturating at 16. On synchronized cs_n=1, go to COMMIT.
  - COMMIT (one cycle), then IDLE:
    - If bit_cnt==16: word_out <= shift, word_valid=1, register write performed.
    - Else: frame_err=1; word_out and the registers are unchanged.
- Overlong frames: more than 16 sck edges means the last 16 bits are kept (shift-register semantics), and the frame is committed normally.
- A sck edge and a cs_n rise detected in the same cycle: the edge is shifted first, then the transition to COMMIT happens.
- Commit latency: the cs_n rise is first seen high at the input of sync stage 1 at edge k. word_valid is high during the cycle after edge k+SYNC_STAGES+1. Registers show the new value in that same cycle.
- Address decode on word[11:8]; word[15:12] is ignored; data = word[7:0].
  - 0x0: no-op; word_valid still pulses.
  - 0x1-0x8: write digit (addr-1), only if addr<=NUM_DIGITS.
  - 0x9: decode_mode. 0xA: intensity <= data[3:0]. 0xB: scan_limit <= data[2:0]. 0xC: shutdown_n <= data[0]. 0xF: display_test <= data[0].
  - 0xD, 0xE: ignored; word_valid still pulses.
- Writes to a register while shutdown_n=0 are accepted; shutdown does not block programming.
- word_valid and frame_err are never high in the same cycle.
- Reset mid-frame: everything is cleared and the block re-enters SYNC_WAIT. The remainder of the interrupted frame produces neither word_valid nor frame_err.

Test Plan:
- Frame 0x0C01 at sck=clk/4, then cs_n high -> word_valid pulses once, word_out=0x0C01, shutdown_n=1, all other registers stay 0.
- Frames 0x093F, 0x0B05, 0x0A07 -> decode_mode=0x3F, scan_limit=5, intensity=7. word_valid pulses 3 times. Latency from cs_n rise to word_valid is SYNC_STAGES+2 clk edges.
- Digit sweep: frames 0x0103, 0x0205, 0x0389, 0x0402, 0x0587, 0x0601 -> digits[7:0]=0x03, [15:8]=0x05, [23:16]=0x89, [31:24]=0x02, [39:32]=0x87, [47:40]=0x01; digits 6-7 stay 0.
- Short frame: 9 sck edges then cs_n high -> frame_err pulses once, no word_valid, word_out and registers unchanged. Overlong frame: 20 edges of bits 0xA_0F07 -> word_out=0x0F07, display_test=1.
- Reset mid-frame: assert res after 8 bits of 0x0109, keep cs_n low and finish the frame -> no word_valid and no frame_err, digit 0 stays 0x00. The next full frame 0x0109 sets digit 0 = 0x09.
- Ignored addresses: 0x0DFF, 0x0EFF, 0x00FF, and 0x09FF (sent with NUM_DIGITS=8) -> word_valid pulses for each. Only decode_mode changes, to 0xFF; all other registers unchanged.
